// File: rtl/mac_tile_scheduler.sv
// Tile sequencer for the MAC streamer: issues paired A-load/D-store requests per tile and waits for both dones.
// Optional cycle counters (busy, stalled ISSUE) are built when MAC_TILE_SCHED_PERF_EN is defined.
module mac_tile_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int TILE_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] a_base_i,
    input  logic [ADDR_WIDTH-1:0] a_stride_i,
    input  logic [ADDR_WIDTH-1:0] d_base_i,
    input  logic [ADDR_WIDTH-1:0] d_stride_i,
    input  logic [LEN_WIDTH-1:0]  tile_len_i,
    input  logic [TILE_WIDTH-1:0] nb_tiles_i,
    input  logic                  a_ready_start_i,
    input  logic                  a_done_i,
    input  logic                  d_ready_start_i,
    input  logic                  d_done_i,
    output logic                  a_req_start_o,
    output logic [ADDR_WIDTH-1:0] a_addr_o,
    output logic [LEN_WIDTH-1:0]  a_trans_size_o,
    output logic                  d_req_start_o,
    output logic [ADDR_WIDTH-1:0] d_addr_o,
    output logic [LEN_WIDTH-1:0]  d_trans_size_o,
    output logic [TILE_WIDTH-1:0] tile_idx_o,
    output logic                  busy_o,
`ifdef MAC_TILE_SCHED_PERF_EN
    output logic [31:0]           perf_busy_o,
    output logic [31:0]           perf_stall_o,
`endif
    output logic                  done_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_NEXT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
    logic [ADDR_WIDTH-1:0] d_addr_q, d_addr_d;
    logic [ADDR_WIDTH-1:0] a_stride_q, a_stride_d;
    logic [ADDR_WIDTH-1:0] d_stride_q, d_stride_d;
    logic [LEN_WIDTH-1:0]  size_q, size_d;
    logic [TILE_WIDTH-1:0] tile_idx_q, tile_idx_d;
    logic [TILE_WIDTH-1:0] nb_tiles_q, nb_tiles_d;
    logic                  a_seen_q, a_seen_d;
    logic                  d_seen_q, d_seen_d;
    logic                  fire;
    logic                  soft_rst;

    assign soft_rst = rst_i | clear_i;
    // Both requests share one handshake so source and sink always start the same tile together.
    assign fire     = (state_q == S_ISSUE) & a_ready_start_i & d_ready_start_i;

    always_comb begin
        state_d    = state_q;
        a_addr_d   = a_addr_q;
        d_addr_d   = d_addr_q;
        a_stride_d = a_stride_q;
        d_stride_d = d_stride_q;
        size_d     = size_q;
        tile_idx_d = tile_idx_q;
        nb_tiles_d = nb_tiles_q;
        a_seen_d   = a_seen_q;
        d_seen_d   = d_seen_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_addr_d   = a_base_i;
                    d_addr_d   = d_base_i;
                    a_stride_d = a_stride_i;
                    d_stride_d = d_stride_i;
                    size_d     = tile_len_i;
                    nb_tiles_d = nb_tiles_i;
                    tile_idx_d = '0;
                    if (nb_tiles_i == '0 || tile_len_i == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (fire) begin
                    a_seen_d = 1'b0;
                    d_seen_d = 1'b0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // Current-cycle pulses count, so same-cycle dones leave immediately.
                a_seen_d = a_seen_q | a_done_i;
                d_seen_d = d_seen_q | d_done_i;
                if (a_seen_d && d_seen_d) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (tile_idx_q == nb_tiles_q - TILE_WIDTH'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    tile_idx_d = tile_idx_q + TILE_WIDTH'(1);
                    a_addr_d   = a_addr_q + a_stride_q;
                    d_addr_d   = d_addr_q + d_stride_q;
                    state_d    = S_ISSUE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_q    <= S_IDLE;
            a_addr_q   <= '0;
            d_addr_q   <= '0;
            a_stride_q <= '0;
            d_stride_q <= '0;
            size_q     <= '0;
            tile_idx_q <= '0;
            nb_tiles_q <= '0;
            a_seen_q   <= 1'b0;
            d_seen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_addr_q   <= a_addr_d;
            d_addr_q   <= d_addr_d;
            a_stride_q <= a_stride_d;
            d_stride_q <= d_stride_d;
            size_q     <= size_d;
            tile_idx_q <= tile_idx_d;
            nb_tiles_q <= nb_tiles_d;
            a_seen_q   <= a_seen_d;
            d_seen_q   <= d_seen_d;
        end
    end

    assign a_req_start_o  = fire;
    assign d_req_start_o  = fire;
    assign a_addr_o       = a_addr_q;
    assign d_addr_o       = d_addr_q;
    assign a_trans_size_o = size_q;
    assign d_trans_size_o = size_q;
    assign tile_idx_o     = tile_idx_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_FINISH);

`ifdef MAC_TILE_SCHED_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i) begin
        if (soft_rst || (state_q == S_IDLE && start_i)) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_o && perf_busy_q != '1) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (state_q == S_ISSUE && !fire && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy_o  = perf_busy_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule
